// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store path.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Replicate the lane MSB unless the load asked for zero extension.
  function automatic logic ext_bit(input logic msb, input logic zext);
    return msb & ~zext;
  endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Little-endian lane steering: store merge into the read word and load extraction/extension.
module ls_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] dm_rd,
  input  logic [31:0] wdata,
  output logic [31:0] merged_wd,
  output logic [31:0] ext_ld,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, merge and extension for the requested access size.
  always_comb begin
    merged_wd = dm_rd;
    ext_ld    = dm_rd;
    misalign  = 1'b0;
    byte_s    = dm_rd[{addr_lo, 3'b000} +: 8];
    half_s    = dm_rd[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged_wd[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        ext_ld = {{24{ext_bit(byte_s[7], ld_unsigned)}}, byte_s};
      end
      SZ_HALF: begin
        misalign = addr_lo[0];
        merged_wd[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        ext_ld = {{16{ext_bit(half_s[15], ld_unsigned)}}, half_s};
      end
      SZ_WORD: begin
        misalign  = (addr_lo != 2'b00);
        merged_wd = wdata;
        ext_ld    = dm_rd;
      end
      default: begin
        // Illegal size is flagged by the parent; keep outputs benign.
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: sub-word access, read-modify-write stores with a
// registered DM write strobe, one stall cycle per store, registered load results.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_WORDS = 24,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              ld_valid,
  output logic              addr_err,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_adr,
  output logic [31:0]       dm_wd,
  input  logic [31:0]       dm_rd
);

  localparam logic [ADDR_W-3:0] WORDS_L = (ADDR_W-2)'(DM_WORDS);

  state_t            state_r, state_n_s;
  logic [ADDR_W-1:0] hold_adr_r;
  logic [31:0]       merged_wd_s;
  logic [31:0]       ext_ld_s;
  logic              misalign_s;
  logic              bad_s;

  ls_lane_align u_align (
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .addr_lo     (addr[1:0]),
    .dm_rd       (dm_rd),
    .wdata       (wdata),
    .merged_wd   (merged_wd_s),
    .ext_ld      (ext_ld_s),
    .misalign    (misalign_s)
  );

  assign bad_s = (size == SZ_ILL) | misalign_s | (addr[ADDR_W-1:2] >= WORDS_L);

  // Next state, DM address mux and pipeline stall.
  always_comb begin
    state_n_s = state_r;
    dm_adr    = addr;
    stall     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        dm_adr = addr;
        stall  = mem_write & ~bad_s;
        if (mem_write & ~bad_s) begin
          state_n_s = ST_WRITE;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // The store is re-presented by the frozen EX/MEM; only the held address counts.
        dm_adr    = hold_adr_r;
        stall     = 1'b0;
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, held address, DM write port and load result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_adr_r <= '0;
      dm_wr      <= 1'b0;
      dm_wd      <= 32'h0000_0000;
      ld_data    <= 32'h0000_0000;
      ld_valid   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      dm_wr    <= 1'b0;
      ld_valid <= 1'b0;
      addr_err <= 1'b0;
      if (state_r == ST_IDLE) begin
        if ((mem_write | mem_read) & bad_s) begin
          addr_err <= 1'b1;
        end else if (mem_write) begin
          hold_adr_r <= addr;
          dm_wd      <= merged_wd_s;
          dm_wr      <= 1'b1;
        end else if (mem_read) begin
          ld_data  <= ext_ld_s;
          ld_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural DM and a load-result scoreboard.
module tb_mem_access_unit;

  localparam int DM_WORDS = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        ld_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        addr_err;
  logic        dm_wr;
  logic [31:0] dm_adr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  logic [31:0] ram [0:31];
  logic        preload = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int total = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_WORDS(DM_WORDS), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .addr_err(addr_err),
    .dm_wr(dm_wr), .dm_adr(dm_adr), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  // DM model: combinational read, write committed at the edge ending a dm_wr cycle
  // unless reset squashes it.
  assign dm_rd = (dm_adr[31:2] < 30'd24) ? ram[dm_adr[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'h1000_0000 + i;
      ram[1] <= 32'h8765_4321;
    end else if (dm_wr && rst_n && dm_adr[31:2] < 30'd24) begin
      ram[dm_adr[6:2]] <= dm_wd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b10; ld_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_write = 1'b1; size = 2'b10; addr = 32'h4; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    addr = 32'h8;
    total++; if (dm_wr !== 1'b0) begin errs++; $display("FAIL reset_dm_wr got=%b want=0", dm_wr); end
    total++; if (dm_wd !== 32'h0) begin errs++; $display("FAIL reset_dm_wd got=%h want=0", dm_wd); end
    total++; if (ld_data !== 32'h0) begin errs++; $display("FAIL reset_ld_data got=%h want=0", ld_data); end
    total++; if (ld_valid !== 1'b0 || addr_err !== 1'b0) begin errs++;
      $display("FAIL reset_pulses got=%b%b want=00", ld_valid, addr_err); end
    #4;
    total++; if (dm_adr !== 32'h8) begin errs++; $display("FAIL reset_idle_adr got=%h want=8", dm_adr); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h7, 32'h7, 32'h6, 32'h4};
    logic [31:0] exs [4] = '{32'hFFFF_FF87, 32'h0000_0087, 32'hFFFF_8765, 32'h0000_4321};
    do_preload();
    for (int i = 0; i < 4; i++) begin
      mem_read = 1'b1; size = szs[i]; ld_unsigned = uns[i]; addr = ads[i];
      exp_q.push_back(exs[i]);
      #4;
      total++; if (stall !== 1'b0) begin errs++; $display("FAIL load%0d_stall got=%b want=0", i, stall); end
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if (ld_valid !== 1'b1 || exp_q.size() == 0) begin
        errs++; $display("FAIL load%0d_valid got=%b want=1", i, ld_valid);
      end else begin
        exp_v = exp_q.pop_front();
        if (ld_data !== exp_v) begin errs++; $display("FAIL load%0d_data got=%h want=%h", i, ld_data, exp_v); end
      end
      @(posedge clk); #1;
      total++; if (ld_valid !== 1'b0) begin errs++; $display("FAIL load%0d_pulse got=%b want=0", i, ld_valid); end
    end
  endtask

  task automatic test_stores();
    logic [1:0]  szs [3] = '{2'b00, 2'b10, 2'b01};
    logic [31:0] ads [3] = '{32'h5, 32'h4, 32'h6};
    logic [31:0] wds [3] = '{32'h0000_00AA, 32'h1234_5678, 32'h0000_BEEF};
    logic [31:0] exs [3] = '{32'h8765_AA21, 32'h1234_5678, 32'hBEEF_5678};
    do_preload();
    for (int i = 0; i < 3; i++) begin
      mem_write = 1'b1; size = szs[i]; addr = ads[i]; wdata = wds[i];
      #4;
      total++; if (stall !== 1'b1 || dm_wr !== 1'b0) begin errs++;
        $display("FAIL st%0d_req got stall=%b dm_wr=%b want 1/0", i, stall, dm_wr); end
      @(posedge clk); #1;
      addr = 32'h0;
      #4;
      total++; if (dm_wr !== 1'b1 || stall !== 1'b0 || dm_adr !== ads[i] || dm_wd !== exs[i]) begin errs++;
        $display("FAIL st%0d_write got wr=%b stall=%b adr=%h wd=%h want 1/0/%h/%h",
                 i, dm_wr, stall, dm_adr, dm_wd, ads[i], exs[i]); end
      @(posedge clk); #1;
      idle_inputs();
      total++; if (dm_wr !== 1'b0) begin errs++; $display("FAIL st%0d_wr_len got=%b want=0", i, dm_wr); end
      total++; if (ram[1] !== exs[i]) begin errs++; $display("FAIL st%0d_ram got=%h want=%h", i, ram[1], exs[i]); end
      mem_read = 1'b1; size = 2'b10; addr = 32'h4;
      exp_q.push_back(exs[i]);
      @(posedge clk); #1;
      idle_inputs();
      total++;
      if (ld_valid !== 1'b1 || exp_q.size() == 0) begin
        errs++; $display("FAIL st%0d_lw_valid got=%b want=1", i, ld_valid);
      end else begin
        exp_v = exp_q.pop_front();
        if (ld_data !== exp_v) begin errs++; $display("FAIL st%0d_lw got=%h want=%h", i, ld_data, exp_v); end
      end
    end
  endtask

  task automatic test_bad();
    logic        wrs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  szs [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] ads [4] = '{32'h6, 32'h5, 32'(4 * DM_WORDS), 32'h4};
    do_preload();
    for (int i = 0; i < 4; i++) begin
      mem_write = wrs[i]; mem_read = ~wrs[i]; size = szs[i]; addr = ads[i]; wdata = 32'h5555_5555;
      #4;
      total++; if (stall !== 1'b0) begin errs++; $display("FAIL bad%0d_stall got=%b want=0", i, stall); end
      @(posedge clk); #1;
      idle_inputs();
      total++; if (addr_err !== 1'b1 || dm_wr !== 1'b0 || ld_valid !== 1'b0) begin errs++;
        $display("FAIL bad%0d_resp got err=%b wr=%b vld=%b want 1/0/0", i, addr_err, dm_wr, ld_valid); end
      @(posedge clk); #1;
      total++; if (addr_err !== 1'b0 || dm_wr !== 1'b0) begin errs++;
        $display("FAIL bad%0d_after got err=%b wr=%b want 0/0", i, addr_err, dm_wr); end
    end
    total++; if (ram[1] !== 32'h8765_4321) begin errs++; $display("FAIL bad_ram got=%h want=87654321", ram[1]); end
  endtask

  task automatic test_reset_in_write();
    do_preload();
    mem_write = 1'b1; size = 2'b00; addr = 32'h4; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    total++; if (dm_wr !== 1'b1) begin errs++; $display("FAIL rstw_enter got=%b want=1", dm_wr); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    total++; if (dm_wr !== 1'b0) begin errs++; $display("FAIL rstw_dm_wr got=%b want=0", dm_wr); end
    total++; if (ram[1] !== 32'h8765_4321) begin errs++; $display("FAIL rstw_ram got=%h want=87654321", ram[1]); end
    mem_read = 1'b1; size = 2'b10; addr = 32'h4;
    exp_q.push_back(32'h8765_4321);
    #4;
    total++; if (stall !== 1'b0 || dm_adr !== 32'h4) begin errs++;
      $display("FAIL rstw_idle got stall=%b adr=%h want 0/4", stall, dm_adr); end
    @(posedge clk); #1;
    idle_inputs();
    total++;
    if (ld_valid !== 1'b1 || exp_q.size() == 0) begin
      errs++; $display("FAIL rstw_lw_valid got=%b want=1", ld_valid);
    end else begin
      exp_v = exp_q.pop_front();
      if (ld_data !== exp_v) begin errs++; $display("FAIL rstw_lw got=%h want=%h", ld_data, exp_v); end
    end
  endtask

  task automatic test_priority();
    do_preload();
    mem_write = 1'b1; mem_read = 1'b1; size = 2'b10; addr = 32'h4; wdata = 32'hCAFE_F00D;
    #4;
    total++; if (stall !== 1'b1) begin errs++; $display("FAIL prio_stall got=%b want=1", stall); end
    @(posedge clk); #1;
    total++; if (ld_valid !== 1'b0 || dm_wr !== 1'b1) begin errs++;
      $display("FAIL prio_resp got vld=%b wr=%b want 0/1", ld_valid, dm_wr); end
    @(posedge clk); #1;
    idle_inputs();
    total++; if (ld_valid !== 1'b0 || ram[1] !== 32'hCAFE_F00D) begin errs++;
      $display("FAIL prio_ram got vld=%b ram=%h want 0/cafef00d", ld_valid, ram[1]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  szs [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h4, 32'h5, 32'h6, 32'h7};
    logic [31:0] exs [4] = '{32'h5A65_4321, 32'h0000_0043, 32'h0000_5A65, 32'h0000_005A};
    int got;
    do_preload();
    mem_write = 1'b1; size = 2'b00; addr = 32'h7; wdata = 32'h0000_005A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    got = 0;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) begin
        mem_read = 1'b1; size = szs[i]; ld_unsigned = uns[i]; addr = ads[i];
        exp_q.push_back(exs[i]);
      end
      @(posedge clk); #1;
      if (ld_valid === 1'b1) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL b2b_extra got=%h want none", ld_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (ld_data !== exp_v) begin errs++; $display("FAIL b2b_data got=%h want=%h", ld_data, exp_v); end
        end
      end
    end
    idle_inputs();
    total++; if (got != 4 || exp_q.size() != 0) begin errs++;
      $display("FAIL b2b_count got=%0d want=4 pending=%0d", got, exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_bad();
    test_reset_in_write();
    test_priority();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, errs);
    $finish;
  end

endmodule
